// File: rtl/job_fifo_sched.sv
// ---------------------------------------------------------------------------
// job_fifo_sched
//
// Round-robin job scheduler. Drains NUM_Q job FIFOs onto one registered output
// stream, one whole job at a time. A job is a run of words that ends with a
// word whose control[LAST_BIT] is set. A job can also be cut off after MAX_JOB
// words. Jobs from different queues never interleave on the output.
//
// Ports
//   clk         rising-edge clock for all logic
//   reset       synchronous, active-high reset
//   en          scheduling enable, looked at only when a new job is picked
//   in_empty    per-queue FIFO empty flags
//   in_data_d   per-queue head data words, queue q at [q*DWIDTH +: DWIDTH]
//   in_data_c   per-queue head control words, packed the same way
//   rd          per-queue pop strobe (one-hot or zero, combinational)
//   out_valid   output register holds a word
//   out_ready   downstream accepts the output word this cycle
//   out_data_d  registered data word
//   out_data_c  registered control word
//   out_qid     source queue of the registered word
//   job_done    one-cycle pulse, aligned with the word that carried EOJ
//   job_trunc   one-cycle pulse, aligned with the word that hit MAX_JOB
// ---------------------------------------------------------------------------
module job_fifo_sched #(
    parameter int NUM_Q    = 4,
    parameter int DWIDTH   = 64,
    parameter int CWIDTH   = 6,
    parameter int LAST_BIT = 0,
    parameter int MAX_JOB  = 256,
    localparam int QW      = (NUM_Q > 1) ? $clog2(NUM_Q) : 1,
    localparam int CNTW    = $clog2(MAX_JOB + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic [NUM_Q-1:0]          in_empty,
    input  logic [NUM_Q*DWIDTH-1:0]   in_data_d,
    input  logic [NUM_Q*CWIDTH-1:0]   in_data_c,
    output logic [NUM_Q-1:0]          rd,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DWIDTH-1:0]         out_data_d,
    output logic [CWIDTH-1:0]         out_data_c,
    output logic [QW-1:0]             out_qid,
    output logic                      job_done,
    output logic                      job_trunc
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t            state_q,     state_d;
    logic [QW-1:0]     rr_ptr_q,    rr_ptr_d;
    logic [QW-1:0]     grant_q,     grant_d;
    logic [CNTW-1:0]   word_cnt_q,  word_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [DWIDTH-1:0] out_word_q,  out_word_d;
    logic [CWIDTH-1:0] out_ctrl_q,  out_ctrl_d;
    logic [QW-1:0]     out_qid_q,   out_qid_d;
    logic              job_done_q,  job_done_d;
    logic              job_trunc_q, job_trunc_d;

    // -----------------------------------------------------------------------
    // Unpack the per-queue head words so they can be indexed by grant
    // -----------------------------------------------------------------------
    logic [DWIDTH-1:0] head_data [NUM_Q];
    logic [CWIDTH-1:0] head_ctrl [NUM_Q];

    generate
        for (genvar gi = 0; gi < NUM_Q; gi++) begin : g_head
            assign head_data[gi] = in_data_d[gi*DWIDTH +: DWIDTH];
            assign head_ctrl[gi] = in_data_c[gi*CWIDTH +: CWIDTH];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Round-robin pick: first non-empty queue at or after rr_ptr, with wrap.
    // The loop runs from the largest offset down so the smallest offset,
    // i.e. the queue closest to rr_ptr, is the last one written and wins.
    // -----------------------------------------------------------------------
    logic          pick_valid;
    logic [QW-1:0] pick_idx;

    always_comb begin
        int            cand;
        logic [QW-1:0] cand_idx;
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int i = NUM_Q - 1; i >= 0; i--) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= NUM_Q) begin
                cand = cand - NUM_Q;
            end
            cand_idx = QW'(cand);
            if (!in_empty[cand_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Pop qualification. A pop needs the output register to be free or being
    // drained this cycle, so a stalled word is never overwritten.
    // -----------------------------------------------------------------------
    logic              pop;
    logic [DWIDTH-1:0] pop_data;
    logic [CWIDTH-1:0] pop_ctrl;
    logic              pop_last;
    logic [CNTW-1:0]   cnt_inc;
    logic              cnt_at_max;
    logic [QW-1:0]     rr_after_grant;

    assign pop        = (state_q == BUSY) && !in_empty[grant_q] &&
                        (!out_valid_q || out_ready);
    assign pop_data   = head_data[grant_q];
    assign pop_ctrl   = head_ctrl[grant_q];
    assign pop_last   = pop_ctrl[LAST_BIT];
    assign cnt_inc    = word_cnt_q + 1'b1;
    assign cnt_at_max = (cnt_inc == CNTW'(MAX_JOB));

    // Next queue after the current grant, wrapping at NUM_Q-1
    assign rr_after_grant = (grant_q == QW'(NUM_Q - 1)) ? '0 : grant_q + 1'b1;

    always_comb begin
        rd = '0;
        if (pop) begin
            rd[grant_q] = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and output-register logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        word_cnt_d  = word_cnt_q;
        out_valid_d = out_valid_q;
        out_word_d  = out_word_q;
        out_ctrl_d  = out_ctrl_q;
        out_qid_d   = out_qid_q;
        job_done_d  = 1'b0;
        job_trunc_d = 1'b0;

        // Output register: load on pop, otherwise empty once accepted
        if (pop) begin
            out_valid_d = 1'b1;
            out_word_d  = pop_data;
            out_ctrl_d  = pop_ctrl;
            out_qid_d   = grant_q;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (en && pick_valid) begin
                    grant_d    = pick_idx;
                    word_cnt_d = '0;
                    state_d    = BUSY;
                end
            end

            BUSY: begin
                // With no pop (empty grant queue or stalled output) the
                // grant is held; no other queue is looked at mid-job.
                if (pop) begin
                    word_cnt_d = cnt_inc;
                    if (pop_last) begin
                        // EOJ takes priority when it also lands on MAX_JOB
                        job_done_d = 1'b1;
                        state_d    = IDLE;
                        rr_ptr_d   = rr_after_grant;
                    end else if (cnt_at_max) begin
                        job_trunc_d = 1'b1;
                        state_d     = IDLE;
                        rr_ptr_d    = rr_after_grant;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            word_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
            out_ctrl_q  <= '0;
            out_qid_q   <= '0;
            job_done_q  <= 1'b0;
            job_trunc_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            word_cnt_q  <= word_cnt_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
            out_ctrl_q  <= out_ctrl_d;
            out_qid_q   <= out_qid_d;
            job_done_q  <= job_done_d;
            job_trunc_q <= job_trunc_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data_d = out_word_q;
    assign out_data_c = out_ctrl_q;
    assign out_qid    = out_qid_q;
    assign job_done   = job_done_q;
    assign job_trunc  = job_trunc_q;

endmodule

// File: tb/tb_job_fifo_sched.sv
// ---------------------------------------------------------------------------
// tb_job_fifo_sched
//
// Scoreboard bench for job_fifo_sched (NUM_Q=4, MAX_JOB=4). A small FIFO model
// per queue feeds the DUT and pops on rd. Each directed test pushes its words
// into the FIFO model and its hand-ordered expected output words into a
// scoreboard queue. A monitor on the falling edge pops the scoreboard on
// every accepted output word and also checks the per-cycle rules for rd and
// the pulse outputs.
// ---------------------------------------------------------------------------
module tb_job_fifo_sched;

    localparam int NQ = 4;
    localparam int DW = 64;
    localparam int CW = 6;
    localparam int MJ = 4;
    localparam int QW = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [NQ-1:0]    in_empty;
    logic [NQ*DW-1:0] in_data_d;
    logic [NQ*CW-1:0] in_data_c;
    logic [NQ-1:0]    rd;
    logic             out_valid;
    logic             out_ready;
    logic [DW-1:0]    out_data_d;
    logic [CW-1:0]    out_data_c;
    logic [QW-1:0]    out_qid;
    logic             job_done;
    logic             job_trunc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    job_fifo_sched #(
        .NUM_Q    (NQ),
        .DWIDTH   (DW),
        .CWIDTH   (CW),
        .LAST_BIT (0),
        .MAX_JOB  (MJ)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .in_empty   (in_empty),
        .in_data_d  (in_data_d),
        .in_data_c  (in_data_c),
        .rd         (rd),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data_d (out_data_d),
        .out_data_c (out_data_c),
        .out_qid    (out_qid),
        .job_done   (job_done),
        .job_trunc  (job_trunc)
    );

    // ---------------- FIFO model ----------------
    logic [DW-1:0] fd   [NQ][32];
    logic [CW-1:0] fc   [NQ][32];
    logic [4:0]    head [NQ] = '{default: 5'd0};
    logic [4:0]    tail [NQ] = '{default: 5'd0};

    always_comb begin
        in_empty  = '0;
        in_data_d = '0;
        in_data_c = '0;
        for (int q = 0; q < NQ; q++) begin
            in_empty[q]          = (head[q] == tail[q]);
            in_data_d[q*DW +: DW] = fd[q][head[q]];
            in_data_c[q*CW +: CW] = fc[q][head[q]];
        end
    end

    always @(posedge clk) begin
        for (int q = 0; q < NQ; q++) begin
            if (rd[q] && (head[q] != tail[q])) begin
                head[q] <= head[q] + 5'd1;
            end
        end
    end

    function automatic logic [DW-1:0] mk_d(int q, int j, int w);
        return {16'hD0B0 + 16'(q), 16'(j + 1), 32'hA500_0000 + 32'(w * 17 + q)};
    endfunction

    function automatic logic [CW-1:0] mk_c(int w, bit last);
        return {5'(w + 1), last};
    endfunction

    task automatic put(input int q, input int j, input int w, input bit last);
        fd[q][tail[q]] = mk_d(q, j, w);
        fc[q][tail[q]] = mk_c(w, last);
        tail[q]        = tail[q] + 5'd1;
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [QW-1:0] qid;
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic          done;
        logic          trunc;
    } exp_t;

    exp_t sb [$];

    task automatic expect_w(input int q, input int j, input int w, input bit last,
                            input bit done, input bit trunc);
        exp_t e;
        e.qid   = QW'(q);
        e.d     = mk_d(q, j, w);
        e.c     = mk_c(w, last);
        e.done  = done;
        e.trunc = trunc;
        sb.push_back(e);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    logic          fresh      = 1'b0;
    logic          done_lat   = 1'b0;
    logic          trunc_lat  = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data  = '0;

    // A word in the output register is new in the cycle after a pop
    always @(posedge clk) fresh <= (|rd) && !reset;

    always @(negedge clk) begin
        if (reset) begin
            prev_stall <= 1'b0;
        end else begin
            check("rd_to_empty", 64'(rd & in_empty), 64'd0);
            check("rd_onehot", 64'($onehot0(rd)), 64'd1);
            if (out_valid && !out_ready) check("rd_while_stalled", 64'(rd), 64'd0);
            if (job_done || job_trunc) check("rd_in_bubble", 64'(rd), 64'd0);
            if (fresh) begin
                done_lat  <= job_done;
                trunc_lat <= job_trunc;
            end else begin
                check("stray_pulse", 64'({job_done, job_trunc}), 64'd0);
            end
            if (prev_stall && !fresh && out_valid) check("hold_data", out_data_d, prev_data);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got qid=%0d data=%h, required no word",
                             out_qid, out_data_d);
                end else begin
                    $display("word qid=%0d data=%h ctrl=%h done=%0d trunc=%0d", out_qid,
                             out_data_d, out_data_c, fresh ? job_done : done_lat,
                             fresh ? job_trunc : trunc_lat);
                    check("word_qid", 64'(out_qid), 64'(sb[0].qid));
                    check("word_data", out_data_d, sb[0].d);
                    check("word_ctrl", 64'(out_data_c), 64'(sb[0].c));
                    check("word_done", 64'(fresh ? job_done : done_lat), 64'(sb[0].done));
                    check("word_trunc", 64'(fresh ? job_trunc : trunc_lat), 64'(sb[0].trunc));
                    void'(sb.pop_front());
                end
            end
            prev_stall <= out_valid && !out_ready;
            prev_data  <= out_data_d;
        end
    end

    // ---------------- helpers ----------------
    // Inputs change 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_%s: got %0d words outstanding, required 0", name, sb.size());
            sb.delete();
        end
        repeat (4) tick();
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_rd"},    64'(rd), 64'd0);
        check({name, "_valid"}, 64'(out_valid), 64'd0);
        check({name, "_data"},  out_data_d, 64'd0);
        check({name, "_ctrl"},  64'(out_data_c), 64'd0);
        check({name, "_qid"},   64'(out_qid), 64'd0);
        check({name, "_done"},  64'(job_done), 64'd0);
        check({name, "_trunc"}, 64'(job_trunc), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    logic [NQ-1:0] t1_rd   [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    logic          t1_done [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic          bp_pat  [12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
                                    1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        reset     = 1'b1;
        en        = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();
        check_outputs_zero("reset");
        reset = 1'b0;
        en    = 1'b1;

        // Single job on queue 2, then rr_ptr must sit at 3
        tick();
        put(2, 0, 0, 0); put(2, 0, 1, 0); put(2, 0, 2, 1);
        expect_w(2, 0, 0, 0, 0, 0);
        expect_w(2, 0, 1, 0, 0, 0);
        expect_w(2, 0, 2, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("single_rd", 64'(rd), 64'(t1_rd[i]));
            check("single_done", 64'(job_done), 64'(t1_done[i]));
            if (i == 0) check("single_first_valid", 64'(out_valid), 64'd0);
            if (i == 1) check("single_second_valid", 64'(out_valid), 64'd1);
        end
        drain("single", 40);
        put(0, 1, 0, 1); put(3, 1, 0, 1);
        expect_w(3, 1, 0, 1, 1, 0);
        expect_w(0, 1, 0, 1, 1, 0);
        drain("rr_ptr3", 40);

        // Round robin over four queues with two 2-word jobs each
        do_reset();
        for (int q = 0; q < NQ; q++) begin
            for (int j = 0; j < 2; j++) begin
                put(q, j, 0, 0); put(q, j, 1, 1);
            end
        end
        for (int j = 0; j < 2; j++) begin
            for (int q = 0; q < NQ; q++) begin
                expect_w(q, j, 0, 0, 0, 0);
                expect_w(q, j, 1, 1, 1, 0);
            end
        end
        drain("round_robin", 120);

        // Backpressure on a 4-word job; EOJ lands on MAX_JOB so only done
        do_reset();
        for (int w = 0; w < 4; w++) put(1, 0, w, w == 3);
        for (int w = 0; w < 4; w++) expect_w(1, 0, w, w == 3, w == 3, 0);
        for (int i = 0; i < 12; i++) begin
            tick();
            out_ready = bp_pat[i];
        end
        out_ready = 1'b1;
        drain("backpressure", 60);

        // Queue 1 starves mid-job while queue 3 waits
        do_reset();
        put(1, 0, 0, 0); put(1, 0, 1, 0);
        put(3, 0, 0, 0); put(3, 0, 1, 1);
        for (int w = 0; w < 4; w++) expect_w(1, 0, w, w == 3, w == 3, 0);
        expect_w(3, 0, 0, 0, 0, 0);
        expect_w(3, 0, 1, 1, 1, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("starve_no_rd3", 64'(rd[3]), 64'd0);
        end
        put(1, 0, 2, 0); put(1, 0, 3, 1);
        drain("starvation", 60);

        // Truncation at MAX_JOB=4 on queue 0, queue 2 served before regrant
        do_reset();
        for (int w = 0; w < 7; w++) put(0, 0, w, w == 6);
        put(2, 0, 0, 1);
        for (int w = 0; w < 4; w++) expect_w(0, 0, w, 0, 0, w == 3);
        expect_w(2, 0, 0, 1, 1, 0);
        for (int w = 4; w < 7; w++) expect_w(0, 0, w, w == 6, w == 6, 0);
        drain("truncation", 80);

        // Reset mid-job with a stalled word, then enable gating
        do_reset();
        out_ready = 1'b0;
        put(2, 0, 0, 0); put(2, 0, 1, 0);
        repeat (4) tick();
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_qid", 64'(out_qid), 64'd2);
        en    = 1'b0;
        reset = 1'b1;
        tick();
        check_outputs_zero("mid_reset");
        reset     = 1'b0;
        out_ready = 1'b1;
        put(0, 1, 0, 0); put(0, 1, 1, 1);
        put(2, 0, 2, 0); put(2, 0, 3, 1);
        expect_w(0, 1, 0, 0, 0, 0);
        expect_w(0, 1, 1, 1, 1, 0);
        expect_w(2, 0, 1, 0, 0, 0);
        expect_w(2, 0, 2, 0, 0, 0);
        expect_w(2, 0, 3, 1, 1, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("en_off_rd", 64'(rd), 64'd0);
            check("en_off_valid", 64'(out_valid), 64'd0);
        end
        en = 1'b1;
        drain("reset_enable", 60);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
